gpio_regblock: RTL



---
 rtl/gpio_regblock_pkg.sv | 36 +++
 rtl/gpio_sync_edge.sv | 52 +++++
 rtl/gpio_regblock.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gpio_regblock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_regblock_pkg
// Brief    : Register addresses, default ID values and edge-select encoding
//            shared by the GPIO register block.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_regblock_pkg;

    localparam logic [2:0] ADDR_NAME     = 3'd0;
    localparam logic [2:0] ADDR_VERSION  = 3'd1;
    localparam logic [2:0] ADDR_OE       = 3'd2;
    localparam logic [2:0] ADDR_PIN      = 3'd3;
    localparam logic [2:0] ADDR_DOUT     = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EDGE = 3'd6;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd7;

    localparam logic [31:0] DEFAULT_CHIP_NAME    = 32'h48524a44;
    localparam logic [31:0] DEFAULT_CHIP_VERSION = 32'h00000002;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    // Expand 4 byte enables into a 32-bit per-bit write mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage : gpio_regblock_pkg
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_edge
// Brief    : Multi-stage pad synchroniser with rise/fall detection, gated by
//            an arm counter so pins already high at reset release are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
    parameter int GPIO_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] sync_pin_o,
    output logic [GPIO_WIDTH-1:0] rise_o,
    output logic [GPIO_WIDTH-1:0] fall_o
);

    localparam int                 c_CNT_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [c_CNT_W-1:0] c_ARM_CNT = c_CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
    logic [GPIO_WIDTH-1:0]                  prev_q;
    logic [c_CNT_W-1:0]                     arm_cnt_q;
    logic [c_CNT_W-1:0]                     arm_cnt_d;
    logic                                   w_armed;

    assign w_armed   = (arm_cnt_q == c_ARM_CNT);
    assign arm_cnt_d = w_armed ? arm_cnt_q : arm_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q    <= sync_q[SYNC_STAGES-1];
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign sync_pin_o = sync_q[SYNC_STAGES-1];
    assign rise_o     = {GPIO_WIDTH{w_armed}} &  sync_pin_o & ~prev_q;
    assign fall_o     = {GPIO_WIDTH{w_armed}} & ~sync_pin_o &  prev_q;

endmodule : gpio_sync_edge
`default_nettype wire

// File: rtl/gpio_regblock.sv
`default_nettype none
// ============================================================================
// Module   : gpio_regblock
// Brief    : Memory-mapped GPIO control/status registers with registered
//            reads, synchronised pin sampling and W1C edge interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_regblock
    import gpio_regblock_pkg::*;
#(
    parameter int          GPIO_WIDTH   = 16,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] CHIP_NAME    = DEFAULT_CHIP_NAME,
    parameter logic [31:0] CHIP_VERSION = DEFAULT_CHIP_VERSION
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  r_wn,
    input  logic [4:2]            addr,
    input  logic [3:0]            wben,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  rvalid,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] oe_q,   oe_d;
    logic [GPIO_WIDTH-1:0] dout_q, dout_d;
    logic [GPIO_WIDTH-1:0] mask_q, mask_d;
    logic [GPIO_WIDTH-1:0] edge_q, edge_d;
    logic [GPIO_WIDTH-1:0] stat_q, stat_d;
    logic                  irq_q,  irq_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic [GPIO_WIDTH-1:0] w_sync_pin, w_rise, w_fall, w_set, w_clr;
    logic [GPIO_WIDTH-1:0] w_wmask, w_wval;
    logic [31:0]           w_be_bits;
    logic                  w_wr, w_rd;

    gpio_sync_edge #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .gpio_i     (gpio_in),
        .sync_pin_o (w_sync_pin),
        .rise_o     (w_rise),
        .fall_o     (w_fall)
    );

    generate
        for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_edge_sel
            assign w_set[i] = (edge_q[i] == EDGE_FALL) ? w_fall[i] : w_rise[i];
        end
    endgenerate

    assign w_wr      = req & ~r_wn;
    assign w_rd      = req &  r_wn;
    assign w_be_bits = byte_mask(wben);
    assign w_wmask   = w_be_bits[GPIO_WIDTH-1:0];
    assign w_wval    = wdata[GPIO_WIDTH-1:0];

    // Lanes above the pin count are architecturally dropped.
    generate
        if (GPIO_WIDTH < 32) begin : g_unused
            logic w_unused;
            assign w_unused = ^{wdata[31:GPIO_WIDTH], w_be_bits[31:GPIO_WIDTH]};
        end
    endgenerate

    always_comb begin
        oe_d     = oe_q;
        dout_d   = dout_q;
        mask_d   = mask_q;
        edge_d   = edge_q;
        w_clr    = '0;
        rdata_d  = rdata_q;
        rvalid_d = w_rd;
        if (w_wr) begin
            case (addr)
                ADDR_OE:       oe_d   = (oe_q   & ~w_wmask) | (w_wval & w_wmask);
                ADDR_DOUT:     dout_d = (dout_q & ~w_wmask) | (w_wval & w_wmask);
                ADDR_IRQ_MASK: mask_d = (mask_q & ~w_wmask) | (w_wval & w_wmask);
                ADDR_IRQ_EDGE: edge_d = (edge_q & ~w_wmask) | (w_wval & w_wmask);
                ADDR_IRQ_STAT: w_clr  = w_wval & w_wmask;
                default:       ;
            endcase
        end
        // A fresh edge in the same cycle as its clear keeps the bit set.
        stat_d = (stat_q & ~w_clr) | w_set;
        irq_d  = |(stat_q & mask_q);
        if (w_rd) begin
            case (addr)
                ADDR_NAME:     rdata_d = CHIP_NAME;
                ADDR_VERSION:  rdata_d = CHIP_VERSION;
                ADDR_OE:       rdata_d = 32'(oe_q);
                ADDR_PIN:      rdata_d = 32'(w_sync_pin);
                ADDR_DOUT:     rdata_d = 32'(dout_q);
                ADDR_IRQ_MASK: rdata_d = 32'(mask_q);
                ADDR_IRQ_EDGE: rdata_d = 32'(edge_q);
                ADDR_IRQ_STAT: rdata_d = 32'(stat_q);
                default:       rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oe_q     <= '0;
            dout_q   <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            stat_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            stat_q   <= stat_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign gpio_out = dout_q;
    assign gpio_oe  = oe_q;
    assign irq      = irq_q;

endmodule : gpio_regblock
`default_nettype wire
